// File: rtl/cpu_seq_if.sv
// Memory bus between cpu_seq (master) and an instruction/data memory (slave).
// Signal names follow the sequencer's memory port names.
interface cpu_seq_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
) ();
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i
    );
endinterface

// File: rtl/cpu_seq.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, writeback.
// Define TANGLE_IRQ_EN to build in single-level interrupt entry/return support.
module cpu_seq #(
    parameter int unsigned       DATA_W  = 16,
    parameter int unsigned       ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] IRQ_VEC = ADDR_W'(2)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    cpu_seq_if.master         mem,
    input  logic [1:0]        dec_nextpc_i,
    input  logic              dec_load_i,
    input  logic              dec_store_i,
    input  logic              dec_regwe_i,
    input  logic [DATA_W-1:0] dec_imm_i,
    input  logic              dec_iret_i,
    input  logic [DATA_W-1:0] reg_data1_i,
    input  logic [DATA_W-1:0] alu_addr_i,
    input  logic              alu_busy_i,
    output logic [DATA_W-1:0] insn_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] link_o,
    output logic [DATA_W-1:0] load_data_o,
    output logic              reg_we_o,
    output logic              alu_start_o,
    input  logic              irq_i,
    output logic              irq_ack_o
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, WAIT_ALU, MEM, WB
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] pc_calc;
    logic              ack_ok;

`ifdef TANGLE_IRQ_EN
    logic [ADDR_W-1:0] epc_q;
    logic              ie_q;
    logic              irq_ack_q;
`endif

    function automatic logic [ADDR_W-1:0] calc_next_pc(
        input logic [1:0]        sel,
        input logic [ADDR_W-1:0] pc,
        input logic [ADDR_W-1:0] imm,
        input logic [ADDR_W-1:0] tgt
    );
        case (sel)
            2'b01:   return pc + imm;
            2'b10:   return tgt;
            default: return pc + ADDR_W'(1);
        endcase
    endfunction

    assign pc_calc = calc_next_pc(dec_nextpc_i, pc_q, dec_imm_i[ADDR_W-1:0],
                                  reg_data1_i[ADDR_W-1:0]);
    // An ack only counts while a request is actually outstanding.
    assign ack_ok  = req_q && mem.mem_ack_i;

    assign mem.mem_req_o   = req_q;
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = (state == MEM) ? alu_addr_i[ADDR_W-1:0] : pc_q;
    assign mem.mem_wdata_o = reg_data1_i;

    assign pc_o   = pc_q;
    assign link_o = pc_q + ADDR_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            pc_q        <= '0;
            insn_o      <= '0;
            load_data_o <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            reg_we_o    <= 1'b0;
            alu_start_o <= 1'b0;
`ifdef TANGLE_IRQ_EN
            epc_q       <= '0;
            ie_q        <= 1'b1;
            irq_ack_q   <= 1'b0;
`endif
        end else begin
            alu_start_o <= 1'b0;
            reg_we_o    <= 1'b0;
`ifdef TANGLE_IRQ_EN
            irq_ack_q   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                    we_q  <= 1'b0;
                end
                FETCH: begin
                    if (ack_ok) begin
                        insn_o      <= mem.mem_rdata_i;
                        req_q       <= 1'b0;
                        alu_start_o <= 1'b1;
                        state       <= DECODE;
                    end
                end
                DECODE: state <= EXEC;
                EXEC: begin
                    if (dec_load_i || dec_store_i) begin
                        state <= MEM;
                        req_q <= 1'b1;
                        we_q  <= dec_store_i;
                    end else if (alu_busy_i) begin
                        state <= WAIT_ALU;
                    end else begin
                        state    <= WB;
                        reg_we_o <= dec_regwe_i;
                    end
                end
                WAIT_ALU: begin
                    if (!alu_busy_i) begin
                        state    <= WB;
                        reg_we_o <= dec_regwe_i;
                    end
                end
                MEM: begin
                    if (ack_ok) begin
                        if (dec_load_i) load_data_o <= mem.mem_rdata_i;
                        req_q    <= 1'b0;
                        we_q     <= 1'b0;
                        reg_we_o <= dec_regwe_i;
                        state    <= WB;
                    end
                end
                WB: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                    we_q  <= 1'b0;
`ifdef TANGLE_IRQ_EN
                    // Return wins over a new interrupt arriving in the same writeback.
                    if (dec_iret_i) begin
                        pc_q <= epc_q;
                        ie_q <= 1'b1;
                    end else if (irq_i && ie_q) begin
                        epc_q     <= pc_calc;
                        pc_q      <= IRQ_VEC;
                        ie_q      <= 1'b0;
                        irq_ack_q <= 1'b1;
                    end else begin
                        pc_q <= pc_calc;
                    end
`else
                    pc_q <= pc_calc;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TANGLE_IRQ_EN
    assign irq_ack_o = irq_ack_q;
`else
    logic unused_irq;
    assign unused_irq = irq_i ^ dec_iret_i;
    assign irq_ack_o  = 1'b0;
`endif

endmodule

// File: doc/cpu_seq.md
CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 16: datapath/instruction width.
REQ-002 SHALL have parameter ADDR_W, default 16: program counter and memory address width.
REQ-003 SHALL have parameter IRQ_VEC, default 2: interrupt entry address (ADDR_W bits).
REQ-004 SHALL use one clock; reset is asynchronous and active-high (ports clk_i, rst_i).
REQ-005 SHALL have ports: clk_i in 1 clock; rst_i in 1 async active-high reset.
REQ-006 SHALL have memory ports: mem_req_o out 1 access request; mem_we_o out 1 write strobe; mem_addr_o out ADDR_W address; mem_wdata_o out DATA_W store data; mem_rdata_i in DATA_W read data; mem_ack_i in 1 access complete this cycle.
REQ-007 SHALL have decoder inputs: dec_nextpc_i in 2 (00 seq, 01 pc+imm, 10 reg, 11 seq); dec_load_i in 1; dec_store_i in 1; dec_regwe_i in 1; dec_imm_i in DATA_W; dec_iret_i in 1.
REQ-008 SHALL have datapath inputs: reg_data1_i in DATA_W (jump target/store data); alu_addr_i in DATA_W (effective address); alu_busy_i in 1.
REQ-009 SHALL have outputs: insn_o out DATA_W latched instruction; pc_o out ADDR_W; link_o out ADDR_W (pc+1); load_data_o out DATA_W; reg_we_o out 1; alu_start_o out 1; irq_i in 1; irq_ack_o out 1.

Function
REQ-010 SHALL implement states IDLE, FETCH, DECODE, EXEC, WAIT_ALU, MEM, WB.
REQ-011 IDLE SHALL go to FETCH on the first clock after reset release.
REQ-012 FETCH SHALL drive mem_req_o=1, mem_we_o=0, mem_addr_o=pc; on mem_ack_i=1 latch mem_rdata_i into insn_o and go to DECODE; otherwise hold (unbounded wait states).
REQ-013 DECODE SHALL last exactly one cycle and pulse alu_start_o=1.
REQ-014 EXEC: dec_load_i or dec_store_i -> MEM; else alu_busy_i=1 -> WAIT_ALU; else -> WB.
REQ-015 WAIT_ALU SHALL hold until alu_busy_i=0, then go to WB.
REQ-016 MEM SHALL drive mem_req_o=1, mem_addr_o=alu_addr_i[ADDR_W-1:0], mem_we_o=dec_store_i, mem_wdata_o=reg_data1_i; on mem_ack_i latch mem_rdata_i into load_data_o (load only) and go to WB.
REQ-017 WB SHALL assert reg_we_o=dec_regwe_i for exactly one cycle, update pc, and go to FETCH.
REQ-018 pc update in WB: 00/11 -> pc+1; 01 -> pc+dec_imm_i[ADDR_W-1:0]; 10 -> reg_data1_i[ADDR_W-1:0]; all modulo 2^ADDR_W (pc=2^ADDR_W-1 seq wraps to 0).
REQ-019 link_o SHALL equal pc+1 modulo 2^ADDR_W combinationally.
REQ-020 mem_ack_i SHALL be ignored while mem_req_o=0; mem_req_o SHALL deassert the cycle after an accepted ack.
REQ-021 Minimum latency non-memory, non-busy instruction: 4 cycles (FETCH with same-cycle ack, DECODE, EXEC, WB).
REQ-022 A store writing address pc+1 SHALL be visible to the next FETCH since fetch always reissues a memory read.

Reset
REQ-023 On rst_i=1, asynchronously: state=IDLE, pc=0, insn_o=0, load_data_o=0, mem_req_o=0, mem_we_o=0, reg_we_o=0, alu_start_o=0, irq_ack_o=0, epc=0, ie=1.
REQ-024 Reset asserted mid-access SHALL drop mem_req_o and mem_we_o immediately; no partial write strobe after reset assertion.

Configuration
REQ-025 Macro TANGLE_IRQ_EN SHALL compile interrupt support in or out.
REQ-026 With TANGLE_IRQ_EN: in WB, if irq_i=1 and ie=1, epc<=computed next pc, pc<=IRQ_VEC, ie<=0, irq_ack_o pulses 1 cycle; the instruction's reg write still occurs.
REQ-027 With TANGLE_IRQ_EN: in WB with dec_iret_i=1, pc<=epc, ie<=1; iret has priority over a pending irq_i in the same WB.
REQ-028 Without TANGLE_IRQ_EN: ports kept, irq_i and dec_iret_i ignored, irq_ack_o tied 0.

Verification
REQ-029 Reset release, mem_ack_i always 1, seq non-regwe insns -> pc_o 0,1,2 each 4 cycles; mem_req_o high in FETCH only.
REQ-030 Fetch with ack delayed 3 cycles, mem_rdata_i=0xBEEF -> insn_o=0xBEEF, DECODE entered the cycle after ack, pc unchanged until WB.
REQ-031 Load, alu_addr_i=0x0040, rdata=0x1234 -> mem_addr_o=0x0040, mem_we_o=0, load_data_o=0x1234, reg_we_o one cycle in WB; store reg_data1_i=0x5A5A -> mem_we_o=1, wdata=0x5A5A, reg_we_o=0.
REQ-032 pc=0xFFFF seq -> 0x0000; pc=0x0010 nextpc=01 imm=0xFFFE -> 0x000E; nextpc=10 reg_data1_i=0x0100 -> 0x0100; alu_busy_i high 5 cycles -> WB delayed 5 cycles.
REQ-033 TANGLE_IRQ_EN, irq_i=1 at pc=0x0020 seq -> pc=0x0002, epc=0x0021, irq_ack_o one pulse, second irq ignored; iret -> pc=0x0021; without macro pc=0x0021, irq_ack_o=0.
REQ-034 rst_i asserted during MEM store with ack pending -> mem_we_o=0 same cycle, pc_o=0, restart fetch at 0.
